fake_n64_controller_tx: RTL and testbench
=========================================

FAKE_N64_CONTROLLER_TX -- requirements
Module: fake_n64_controller_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 4, meaning clk cycles per 1 us protocol quarter-bit.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tx_handoff  input  1  toggle from receiver; each edge requests one response.
REQ-005 SHALL have port cmd  input  8  decoded console command, stable while tx_handoff toggles.
REQ-006 SHALL have port address  input  16  READ/WRITE address from receiver.
REQ-007 SHALL have port crc  input  8  receiver-computed WRITE data CRC.
REQ-008 SHALL have port button_state  input  32  button/stick word, MSB sent first.
REQ-009 SHALL have port pak_present  input  1  controller-pak inserted flag.
REQ-010 SHALL have ports rd_en output 1, rd_addr output 16, rd_data input 8  pak byte read, data valid one clk after rd_en.
REQ-011 SHALL have port data_tx  output  1  line level; 0 = drive low, 1 = released.
REQ-012 SHALL have port cur_operation  output  1  high while response in progress (receiver gating).

Function
REQ-013 Handoff SHALL be detected as any toggle of tx_handoff, via a two-flop register and XOR edge detect.
REQ-014 States SHALL be IDLE, TURN, LOAD, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH; IDLE on reset.
REQ-015 IDLE->TURN on detected toggle when cmd is 0x00, 0x01, 0x02, 0x03 or 0xFF; any other cmd SHALL leave FSM in IDLE with data_tx=1.
REQ-016 cur_operation SHALL rise the clk after toggle detection and fall the clk STOP_HIGH exits to IDLE.
REQ-017 TURN SHALL last 2*CLKS_PER_US clks with data_tx=1, then go to LOAD.
REQ-018 Response bytes: 0x00/0xFF -> {0x05, 0x00, {7'b0,pak_present}}; 0x01 -> button_state[31:24..7:0]; 0x02 -> 32 pak bytes then 1 CRC byte; 0x03 -> crc.
REQ-019 READ bytes SHALL be fetched with rd_en one clk in LOAD, rd_addr = {address[15:5],5'b0} + byte index (0..31), 5-bit index wrap within the 32-byte block.
REQ-020 Bits SHALL be sent MSB first; bit 0 = 3 us low then 1 us high; bit 1 = 1 us low then 3 us high (4 us per bit).
REQ-021 After last bit, stop SHALL be 2 us low (STOP_LOW) then 2 us released (STOP_HIGH), then IDLE.
REQ-022 Byte counter SHALL be 6 bits; last-byte compare SHALL use per-command length 3/4/33/1.
REQ-023 Toggles of tx_handoff while cur_operation=1 SHALL be ignored and not queued.
REQ-024 cmd/address/button_state/pak_present/crc SHALL be sampled at LOAD of each byte; changes mid-byte SHALL not affect that byte.

Reset
REQ-025 On reset: FSM=IDLE, data_tx=1, cur_operation=0, rd_en=0, rd_addr=0, counters=0, handoff history := current tx_handoff (no spurious request).
REQ-026 Reset mid-response SHALL release the line (data_tx=1) on the same clk edge and discard the response.

Configuration
REQ-027 With FAKE_N64_READ_CRC_EN defined, READ CRC byte SHALL be computed over the 32 sent data bytes: poly 0x85, init 0x00, MSB first, 8 zero bits appended.
REQ-028 Without FAKE_N64_READ_CRC_EN, READ CRC byte SHALL be 0x00 and no CRC logic SHALL be built.

Structure
REQ-029 Package fake_n64_pkg SHALL hold command codes, response lengths, device ID bytes 0x05/0x00 and CRC polynomial 0x85.
REQ-030 Sub-module fake_n64_tx_crc (byte-serial CRC, enable/clear) SHALL exist, instantiated only under FAKE_N64_READ_CRC_EN.

Verification
REQ-031 cmd=0x00, toggle -> after 8 clks idle, 24 bits 0x05,0x00,0x01 (pak_present=1), stop, cur_operation low; total 8+24*16+16 clks.
REQ-032 cmd=0x01, button_state=0x8000_7F01 -> bits match word MSB first; bit 1 = 4 low/12 high clks, bit 0 = 12 low/4 high.
REQ-033 cmd=0x02, address=0x8025, memory[i]=i -> rd_addr 0x8020..0x803F, 32 bytes then CRC (macro on: reference-model CRC; off: 0x00).
REQ-034 cmd=0x42, toggle -> data_tx stays 1, cur_operation stays 0, rd_en never asserted.
REQ-035 Reset asserted mid-bit of cmd=0x01 response -> data_tx=1 next edge; subsequent cmd=0x03, crc=0xA5 toggle -> single byte 0xA5 then stop.
REQ-036 Second toggle during cmd=0x00 response -> ignored; exactly one response observed.

Source files
------------

// File: rtl/fake_n64_pkg.sv
// Shared constants, state encoding and CRC step for the fake N64 controller transmitter.
// Holds no logic of its own; imported by the transmitter top and its CRC helper.
package fake_n64_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [5:0] LEN_INFO   = 6'd3;
    localparam logic [5:0] LEN_STATUS = 6'd4;
    localparam logic [5:0] LEN_READ   = 6'd33;
    localparam logic [5:0] LEN_WRITE  = 6'd1;

    localparam logic [5:0] READ_DATA_BYTES = 6'd32;

    localparam logic [7:0] DEV_ID0  = 8'h05;
    localparam logic [7:0] DEV_ID1  = 8'h00;
    localparam logic [7:0] CRC_POLY = 8'h85;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        LOAD,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH
    } state_t;

    function automatic logic cmd_supported(input logic [7:0] c);
        case (c)
            CMD_INFO, CMD_STATUS, CMD_READ, CMD_WRITE, CMD_RESET: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] resp_len(input logic [7:0] c);
        case (c)
            CMD_STATUS: return LEN_STATUS;
            CMD_READ:   return LEN_READ;
            CMD_WRITE:  return LEN_WRITE;
            default:    return LEN_INFO;
        endcase
    endfunction

    // Non-augmented form: equals long division with 8 zero bits appended.
    function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/fake_n64_tx_crc.sv
// Byte-serial CRC-8 (poly 0x85) over READ data; only present with FAKE_N64_READ_CRC_EN.
// Result valid the clk after the last enabled byte; clear restarts from 0x00.
`ifdef FAKE_N64_READ_CRC_EN
module fake_n64_tx_crc
    import fake_n64_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule
`endif

// File: rtl/fake_n64_controller_tx.sv
// Fake N64 controller reply serializer (READ CRC byte built only with FAKE_N64_READ_CRC_EN).
// Reply starts 2 us after a handoff toggle; toggles during a reply are dropped, not queued.
module fake_n64_controller_tx
    import fake_n64_pkg::*;
#(
    parameter int CLKS_PER_US = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_handoff,
    input  logic [7:0]  cmd,
    input  logic [15:0] address,
    input  logic [7:0]  crc,
    input  logic [31:0] button_state,
    input  logic        pak_present,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        data_tx,
    output logic        cur_operation
);

    // LOAD is the first low clk of each byte's first bit, so CLKS_PER_US must be >= 2.
    localparam int CW = $clog2(3 * CLKS_PER_US + 1);
    localparam logic [CW-1:0] ONE_US_M1   = CW'(CLKS_PER_US - 1);
    localparam logic [CW-1:0] TWO_US_M1   = CW'(2 * CLKS_PER_US - 1);
    localparam logic [CW-1:0] THREE_US_M1 = CW'(3 * CLKS_PER_US - 1);

    state_t          state;
    logic            hist_q;
    logic            hist_qq;
    logic            toggle;
    logic [7:0]      op;
    logic [5:0]      byte_idx;
    logic [5:0]      last_idx;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            rd_pend;
    logic [CW-1:0]   cnt;
    logic [7:0]      load_byte;
    logic            cur_bit;
    logic [CW-1:0]   low_m1;
    logic [CW-1:0]   high_m1;
    logic [7:0]      read_crc;
    logic            addr_lo_unused;

    assign toggle         = hist_q ^ hist_qq;
    assign addr_lo_unused = ^address[4:0];

    // First low clk after a READ fetch: the byte is still on rd_data, not yet in shift.
    assign cur_bit = rd_pend ? rd_data[7] : shift[7];
    assign low_m1  = cur_bit  ? ONE_US_M1   : THREE_US_M1;
    assign high_m1 = shift[7] ? THREE_US_M1 : ONE_US_M1;

    always_comb begin
        load_byte = 8'h00;
        case (op)
            CMD_INFO, CMD_RESET: begin
                case (byte_idx)
                    6'd0:    load_byte = DEV_ID0;
                    6'd1:    load_byte = DEV_ID1;
                    default: load_byte = {7'b0, pak_present};
                endcase
            end
            CMD_STATUS: begin
                case (byte_idx[1:0])
                    2'd0:    load_byte = button_state[31:24];
                    2'd1:    load_byte = button_state[23:16];
                    2'd2:    load_byte = button_state[15:8];
                    default: load_byte = button_state[7:0];
                endcase
            end
            CMD_READ:  load_byte = (byte_idx == READ_DATA_BYTES) ? read_crc : 8'h00;
            CMD_WRITE: load_byte = crc;
            default:   load_byte = 8'h00;
        endcase
    end

`ifdef FAKE_N64_READ_CRC_EN
    logic crc_clear;
    logic crc_en;

    assign crc_clear = (state == TURN);
    assign crc_en    = (state == BIT_LOW) && rd_pend;

    fake_n64_tx_crc u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clear),
        .en    (crc_en),
        .din   (rd_data),
        .crc   (read_crc)
    );
`else
    assign read_crc = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            data_tx       <= 1'b1;
            cur_operation <= 1'b0;
            rd_en         <= 1'b0;
            rd_addr       <= 16'h0000;
            cnt           <= '0;
            byte_idx      <= 6'd0;
            last_idx      <= 6'd0;
            bit_idx       <= 3'd0;
            shift         <= 8'h00;
            rd_pend       <= 1'b0;
            op            <= 8'h00;
            hist_q        <= tx_handoff;
            hist_qq       <= tx_handoff;
        end else begin
            hist_q  <= tx_handoff;
            hist_qq <= hist_q;
            rd_en   <= 1'b0;
            case (state)
                IDLE: begin
                    data_tx <= 1'b1;
                    if (toggle && cmd_supported(cmd)) begin
                        state         <= TURN;
                        cur_operation <= 1'b1;
                        op            <= cmd;
                        last_idx      <= resp_len(cmd) - 6'd1;
                        byte_idx      <= 6'd0;
                        cnt           <= '0;
                    end
                end
                TURN: begin
                    if (cnt == TWO_US_M1) begin
                        state   <= LOAD;
                        data_tx <= 1'b0;
                        rd_en   <= (op == CMD_READ);
                        rd_addr <= {address[15:5], 5'd0};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    shift   <= load_byte;
                    rd_pend <= (op == CMD_READ) && (byte_idx < READ_DATA_BYTES);
                    bit_idx <= 3'd7;
                    cnt     <= CW'(1);
                    state   <= BIT_LOW;
                end
                BIT_LOW: begin
                    if (rd_pend) begin
                        shift   <= rd_data;
                        rd_pend <= 1'b0;
                    end
                    if (cnt == low_m1) begin
                        state   <= BIT_HIGH;
                        data_tx <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if (cnt == high_m1) begin
                        cnt     <= '0;
                        data_tx <= 1'b0;
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            shift   <= {shift[6:0], 1'b0};
                            state   <= BIT_LOW;
                        end else if (byte_idx != last_idx) begin
                            byte_idx <= byte_idx + 6'd1;
                            state    <= LOAD;
                            rd_en    <= (op == CMD_READ) && (byte_idx < READ_DATA_BYTES - 6'd1);
                            rd_addr  <= {address[15:5], byte_idx[4:0] + 5'd1};
                        end else begin
                            state <= STOP_LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_LOW: begin
                    if (cnt == TWO_US_M1) begin
                        state   <= STOP_HIGH;
                        data_tx <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_HIGH: begin
                    if (cnt == TWO_US_M1) begin
                        state         <= IDLE;
                        cur_operation <= 1'b0;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    data_tx       <= 1'b1;
                    cur_operation <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fake_n64_controller_tx.sv
// Bench for fake_n64_controller_tx: reference model fills expected queues, a line decoder checks.
module tb_fake_n64_controller_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_handoff = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] address = 16'h0000;
    logic [7:0]  crc_in = 8'h00;
    logic [31:0] button_state = 32'h0;
    logic        pak_present = 1'b0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        data_tx;
    logic        cur_operation;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_bytes[$];
    int          exp_len[$];
    logic [15:0] exp_addr[$];

    logic [7:0] mem_mul = 8'd1;
    logic [7:0] mem_xor = 8'h00;

    int frames_done = 0;
    int rd_en_total = 0;
    int low_total   = 0;
    int op_total    = 0;

    always #5 clk = ~clk;

    fake_n64_controller_tx #(.CLKS_PER_US(C)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_handoff    (tx_handoff),
        .cmd           (cmd),
        .address       (address),
        .crc           (crc_in),
        .button_state  (button_state),
        .pak_present   (pak_present),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .data_tx       (data_tx),
        .cur_operation (cur_operation)
    );

    function automatic logic [7:0] memval(input logic [15:0] a);
        logic [7:0] idx;
        idx = {3'b000, a[4:0]};
        return 8'(idx * mem_mul) ^ mem_xor;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= memval(rd_addr);

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: reply bytes as the console should receive them.
    task automatic expect_response(input logic [7:0] c);
        logic [15:0] base;
        logic [7:0]  d;
        logic [7:0]  r;
        logic        fb;
        logic        inb;
        case (c)
            8'h00, 8'hFF: begin
                exp_bytes.push_back(8'h05);
                exp_bytes.push_back(8'h00);
                exp_bytes.push_back({7'b0, pak_present});
                exp_len.push_back(3);
            end
            8'h01: begin
                for (int k = 0; k < 4; k++) exp_bytes.push_back(button_state[31 - 8 * k -: 8]);
                exp_len.push_back(4);
            end
            8'h02: begin
                base = {address[15:5], 5'd0};
                r = 8'h00;
                for (int i = 0; i < 40; i++) begin
                    d = (i < 32) ? memval(base + 16'(i)) : 8'h00;
                    if (i < 32) begin
                        exp_bytes.push_back(d);
                        exp_addr.push_back(base + 16'(i));
                    end
                    // Message bits then 8 appended zeros, divided by x^8+x^7+x^2+1.
                    if (i < 33) begin
                        for (int b = 7; b >= 0; b--) begin
                            inb = d[b];
                            fb  = r[7];
                            r   = {r[6:0], inb};
                            if (fb) r = r ^ 8'h85;
                        end
                    end
                end
`ifdef FAKE_N64_READ_CRC_EN
                exp_bytes.push_back(r);
`else
                exp_bytes.push_back(8'h00);
`endif
                exp_len.push_back(33);
            end
            8'h03: begin
                exp_bytes.push_back(crc_in);
                exp_len.push_back(1);
            end
            default: ;
        endcase
    endtask

    // Line decoder / scoreboard consumer.
    logic        prev_line = 1'b1;
    logic        prev_op = 1'b0;
    int          low_run = 0;
    int          high_run = 0;
    int          nbits = 0;
    int          nbytes = 0;
    int          op_cycles = 0;
    int          exp_high = 0;
    int          el = 0;
    logic [7:0]  shb = 8'h00;
    logic [7:0]  eb = 8'h00;
    logic [15:0] ea = 16'h0;
    bit          pend = 0;
    bit          first_fall = 1;
    bit          stop_seen = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_line = 1'b1; prev_op = 1'b0; low_run = 0; high_run = 0;
            nbits = 0; nbytes = 0; op_cycles = 0; pend = 0; first_fall = 1; stop_seen = 0;
        end else begin
            if (cur_operation && !prev_op) begin
                op_cycles = 0; nbits = 0; nbytes = 0; first_fall = 1; stop_seen = 0; pend = 0;
            end
            if (rd_en) begin
                rd_en_total++;
                if (exp_addr.size() == 0) check(0, "rd_addr_extra", rd_addr, 0);
                else begin
                    ea = exp_addr.pop_front();
                    check(rd_addr == ea, "rd_addr", rd_addr, ea);
                end
            end
            if (!data_tx) low_total++;
            if (!data_tx && prev_line) begin
                if (first_fall) begin
                    check(op_cycles == 2 * C, "turnaround", op_cycles, 2 * C);
                    first_fall = 0;
                end else if (pend) begin
                    check(high_run == exp_high, "bit_high", high_run, exp_high);
                end
                pend = 0;
                low_run = 0;
            end
            if (data_tx && !prev_line) begin
                if (low_run == C || low_run == 3 * C) begin
                    shb = {shb[6:0], (low_run == C)};
                    nbits++;
                    pend = 1;
                    exp_high = 4 * C - low_run;
                    if (nbits == 8) begin
                        nbits = 0;
                        nbytes++;
                        if (exp_bytes.size() == 0) check(0, "byte_extra", shb, 0);
                        else begin
                            eb = exp_bytes.pop_front();
                            check(shb == eb, "byte", shb, eb);
                        end
                    end
                end else if (low_run == 2 * C) begin
                    stop_seen = 1;
                    check(nbits == 0, "stop_align", nbits, 0);
                end else begin
                    check(0, "low_len", low_run, C);
                end
                high_run = 0;
            end
            if (data_tx) high_run++; else low_run++;
            if (cur_operation) begin
                op_cycles++;
                op_total++;
            end
            if (!cur_operation && prev_op) begin
                check(stop_seen, "stop_seen", stop_seen, 1);
                if (exp_len.size() == 0) check(0, "frame_extra", nbytes, 0);
                else begin
                    el = exp_len.pop_front();
                    check(nbytes == el, "frame_len", nbytes, el);
                    check(op_cycles == 2 * C + el * 32 * C + 4 * C, "op_cycles",
                          op_cycles, 2 * C + el * 32 * C + 4 * C);
                end
                frames_done++;
            end
            prev_line = data_tx;
            prev_op   = cur_operation;
        end
    end

    task automatic issue(input logic [7:0] c);
        cmd = c;
        expect_response(c);
        tx_handoff = ~tx_handoff;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!cur_operation && n < 20) begin tick(); n++; end
        check(cur_operation, "start_timeout", cur_operation, 1);
        n = 0;
        while (cur_operation && n < 6000) begin tick(); n++; end
        check(!cur_operation, "end_timeout", cur_operation, 0);
        repeat (4) tick();
    endtask

    logic [7:0] cmd_set[5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF};

    initial begin
        int f0, r0, l0, o0, n;

        repeat (3) tick();
        check(data_tx == 1'b1, "reset_data_tx", data_tx, 1);
        check(cur_operation == 1'b0, "reset_cur_op", cur_operation, 0);
        check(rd_en == 1'b0, "reset_rd_en", rd_en, 0);
        check(rd_addr == 16'h0, "reset_rd_addr", rd_addr, 0);
        reset = 1'b0;
        repeat (5) tick();

        // Device info with pak inserted.
        pak_present = 1'b1;
        issue(8'h00);
        wait_done();

        // Button word, mixed 0/1 runs.
        button_state = 32'h8000_7F01;
        issue(8'h01);
        wait_done();

        // Pak read from an unaligned address, memory[i] = i.
        address = 16'h8025; mem_mul = 8'd1; mem_xor = 8'h00;
        issue(8'h02);
        wait_done();

        // Unsupported command: nothing happens.
        r0 = rd_en_total; l0 = low_total; o0 = op_total;
        issue(8'h42);
        repeat (200) tick();
        check(rd_en_total == r0, "bad_cmd_rd_en", rd_en_total - r0, 0);
        check(low_total == l0, "bad_cmd_line", low_total - l0, 0);
        check(op_total == o0, "bad_cmd_cur_op", op_total - o0, 0);

        // Reset in the middle of a button reply.
        button_state = 32'h0F0F_AA55;
        issue(8'h01);
        n = 0;
        while (!cur_operation && n < 20) begin tick(); n++; end
        check(cur_operation, "abort_start", cur_operation, 1);
        repeat (2 * C + 16 * C * 5 + 6) tick();
        reset = 1'b1;
        exp_bytes.delete(); exp_len.delete(); exp_addr.delete();
        tx_handoff = ~tx_handoff;
        @(posedge clk); #1;
        check(data_tx == 1'b1, "abort_data_tx", data_tx, 1);
        check(cur_operation == 1'b0, "abort_cur_op", cur_operation, 0);
        tick();
        reset = 1'b0;
        o0 = op_total;
        repeat (20) tick();
        check(op_total == o0, "no_spurious_after_reset", op_total - o0, 0);
        crc_in = 8'hA5;
        issue(8'h03);
        wait_done();

        // Second toggle mid-reply is dropped.
        f0 = frames_done;
        pak_present = 1'b0;
        issue(8'h00);
        repeat (100) tick();
        tx_handoff = ~tx_handoff;
        wait_done();
        repeat (40) tick();
        check(frames_done == f0 + 1, "ignored_toggle", frames_done - f0, 1);
        check(cur_operation == 1'b0, "ignored_toggle_idle", cur_operation, 0);

        // Randomized replies.
        for (int t = 0; t < 10; t++) begin
            button_state = $urandom();
            address      = 16'($urandom());
            crc_in       = 8'($urandom());
            pak_present  = 1'($urandom());
            mem_mul      = 8'($urandom()) | 8'h01;
            mem_xor      = 8'($urandom());
            issue(cmd_set[$urandom_range(0, 4)]);
            wait_done();
        end

        check(exp_bytes.size() == 0, "bytes_left", exp_bytes.size(), 0);
        check(exp_len.size() == 0, "frames_left", exp_len.size(), 0);
        check(exp_addr.size() == 0, "reads_left", exp_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
